// File: rtl/synth_cmd_decoder.sv
// ============================================================================
// Module   : synth_cmd_decoder
// Purpose  : Parses header/data words from the SPI FIFO into register writes
//            and a backpressured sample stream. Macro SYNTH_CMD_ERR_CNT_EN
//            enables the saturating frame-error counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module synth_cmd_decoder (
  input  logic        synth_clk,
  input  logic        rst_n,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_read,
  output logic        reg_wr_en,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wr_data,
  output logic [31:0] smp_data,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic        frame_err,
  output logic [15:0] err_count,
  output logic        idle
);

  localparam logic [7:0] c_OP_NOP    = 8'h00;
  localparam logic [7:0] c_OP_WRITE  = 8'h01;
  localparam logic [7:0] c_OP_BURST  = 8'h02;
  localparam logic [7:0] c_OP_STREAM = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR     = 2'd1,
    S_BURST  = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_rst_sync;
  logic [7:0]  r_addr;
  logic [15:0] r_cnt;
  logic        w_run;
  logic        w_word_read;
  logic        w_last;
  logic [7:0]  w_hdr_op;
  logic [7:0]  w_hdr_addr;
  logic [15:0] w_hdr_cnt;

  assign w_hdr_op   = word_data[31:24];
  assign w_hdr_addr = word_data[23:16];
  assign w_hdr_cnt  = word_data[15:0];
  assign w_last     = (r_cnt == 16'd1);

  // Reset asserts asynchronously but the FIFO is only read two edges after release.
  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  always_comb begin
    w_word_read = 1'b0;
    if (w_run && word_valid) begin
      if (r_state == S_STREAM) begin
        w_word_read = !smp_valid || smp_ready;
      end else begin
        w_word_read = 1'b1;
      end
    end
  end

  assign word_read = w_word_read;
  assign idle      = (r_state == S_IDLE) && !smp_valid;

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= 8'h00;
      r_cnt       <= 16'h0000;
      reg_wr_en   <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wr_data <= 32'h0000_0000;
      smp_data    <= 32'h0000_0000;
      smp_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      frame_err <= 1'b0;
      if (smp_valid && smp_ready) begin
        smp_valid <= 1'b0;
      end
      if (w_word_read) begin
        case (r_state)
          S_IDLE: begin
            r_addr <= w_hdr_addr;
            r_cnt  <= w_hdr_cnt;
            case (w_hdr_op)
              c_OP_NOP:    r_state <= S_IDLE;
              c_OP_WRITE:  r_state <= S_WR;
              c_OP_BURST:  r_state <= (w_hdr_cnt != 16'd0) ? S_BURST : S_IDLE;
              c_OP_STREAM: r_state <= (w_hdr_cnt != 16'd0) ? S_STREAM : S_IDLE;
              default:     frame_err <= 1'b1;
            endcase
          end
          S_WR: begin
            reg_wr_en   <= 1'b1;
            reg_addr    <= r_addr;
            reg_wr_data <= word_data;
            r_state     <= S_IDLE;
          end
          S_BURST: begin
            reg_wr_en   <= 1'b1;
            reg_addr    <= r_addr;
            reg_wr_data <= word_data;
            r_addr      <= r_addr + 8'd1;
            r_cnt       <= r_cnt - 16'd1;
            if (w_last) begin
              r_state <= S_IDLE;
            end
          end
          S_STREAM: begin
            smp_data  <= word_data;
            smp_valid <= 1'b1;
            r_cnt     <= r_cnt - 16'd1;
            if (w_last) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SYNTH_CMD_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 16'h0000;
    end else if (frame_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_synth_cmd_decoder.sv
// ============================================================================
// Module   : tb_synth_cmd_decoder
// Purpose  : Self-checking bench for synth_cmd_decoder (frame-level model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_synth_cmd_decoder;

  logic        synth_clk = 1'b0;
  logic        rst_n     = 1'b1;
  logic [31:0] word_data = 32'h0;
  logic        word_valid = 1'b0;
  logic        smp_ready  = 1'b0;
  logic        word_read;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] smp_data;
  logic        smp_valid;
  logic        frame_err;
  logic [15:0] err_count;
  logic        idle;

  synth_cmd_decoder dut (
    .synth_clk   (synth_clk),
    .rst_n       (rst_n),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_read   (word_read),
    .reg_wr_en   (reg_wr_en),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .smp_data    (smp_data),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .frame_err   (frame_err),
    .err_count   (err_count),
    .idle        (idle)
  );

  always #5 synth_clk = ~synth_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO contents and frame-level reference model
  logic [31:0] fifo[$];
  logic [31:0] smp_q[$];
  int          stall_pct = 0;
  bit          rdy_rand  = 0;
  int          rdy_low   = 0;
  int          m_mode    = 0;   // 0 idle, 1 write, 2 burst, 3 stream
  int          m_rem     = 0;
  logic [7:0]  m_addr    = 8'h0;
  bit          m_pend    = 0;
  int          m_errs    = 0;
  int          m_sync    = 0;
  int          obs_wr = 0, obs_smp = 0, obs_err = 0;

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_pend = 0; m_errs = 0; m_sync = 0;
    smp_q.delete();
  endtask

  task automatic model_consume(input logic [31:0] w, output bit ew, output logic [7:0] ea,
                               output logic [31:0] ed, output bit ee);
    int op;
    ew = 0; ee = 0; ea = 8'h0; ed = 32'h0;
    op = int'(w[31:24]);
    if (m_mode == 0) begin
      m_addr = w[23:16];
      m_rem  = int'(w[15:0]);
      if (op == 1) m_mode = 1;
      else if (op == 2) m_mode = (m_rem != 0) ? 2 : 0;
      else if (op == 3) m_mode = (m_rem != 0) ? 3 : 0;
      else if (op != 0) ee = 1;
    end else if (m_mode == 1) begin
      ew = 1; ea = m_addr; ed = w; m_mode = 0;
    end else if (m_mode == 2) begin
      ew = 1; ea = m_addr; ed = w;
      m_addr = m_addr + 8'd1;
      m_rem--;
      if (m_rem == 0) m_mode = 0;
    end else begin
      smp_q.push_back(w);
      m_pend = 1;
      m_rem--;
      if (m_rem == 0) m_mode = 0;
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    bit exp_rd, rd, hs, ew, ee;
    logic [7:0]  ea;
    logic [31:0] ed, w;
    if (fifo.size() != 0 && $urandom_range(99) >= stall_pct) begin
      word_valid = 1'b1; word_data = fifo[0];
    end else begin
      word_valid = 1'b0; word_data = $urandom;
    end
    if (rdy_low > 0) begin
      smp_ready = 1'b0; rdy_low--;
    end else begin
      smp_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    end
    #1;
    exp_rd = word_valid && (m_sync >= 2) && (m_mode != 3 || !m_pend || smp_ready);
    chk("word_read", word_read, exp_rd);
    chk("smp_valid", smp_valid, m_pend);
    chk("idle", idle, (m_mode == 0) && !m_pend);
    if (m_pend) begin
      chk("smp_data", smp_data, (smp_q.size() != 0) ? smp_q[0] : 32'hx);
      if (smp_ready) begin
        obs_smp++;
        if (smp_q.size() != 0) void'(smp_q.pop_front());
      end
    end
    rd = word_read;
    hs = m_pend && smp_ready;
    @(posedge synth_clk);
    if (!rst_n) m_sync = 0;
    else if (m_sync < 2) m_sync++;
    if (hs) m_pend = 0;
    ew = 0; ee = 0; ea = 8'h0; ed = 32'h0;
    if (rd && fifo.size() != 0) begin
      w = fifo.pop_front();
      model_consume(w, ew, ea, ed, ee);
    end
    #1;
    chk("reg_wr_en", reg_wr_en, ew);
    if (ew) begin
      chk("reg_addr", reg_addr, ea);
      chk("reg_wr_data", reg_wr_data, ed);
    end
    chk("frame_err", frame_err, ee);
`ifdef SYNTH_CMD_ERR_CNT_EN
    chk("err_count", err_count, (m_errs > 16'hFFFF) ? 16'hFFFF : m_errs[15:0]);
`else
    chk("err_count", err_count, 16'h0000);
`endif
    if (ee) m_errs++;
    if (reg_wr_en) obs_wr++;
    if (frame_err) obs_err++;
    @(negedge synth_clk);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((fifo.size() != 0 || m_pend || m_mode != 0) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d cycles required < %0d", c, budget);
    end
    tick();
    tick();
  endtask

  task automatic chk_reset_vals();
    chk("rst_word_read", word_read, 1'b0);
    chk("rst_reg_wr_en", reg_wr_en, 1'b0);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_reg_wr_data", reg_wr_data, 32'h0);
    chk("rst_smp_valid", smp_valid, 1'b0);
    chk("rst_smp_data", smp_data, 32'h0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_err_count", err_count, 16'h0);
    chk("rst_idle", idle, 1'b1);
  endtask

  typedef struct {
    string           name;
    int              n;
    logic [4:0][31:0] w;
    int              n_wr;
    int              n_smp;
    int              n_err;
    logic [7:0]      last_addr;
  } vec_t;

  function automatic vec_t mk(input string nm, input int n, input logic [31:0] a, b, c, d, e,
                              input int nwr, nsmp, nerr, input logic [7:0] la);
    vec_t v;
    v.name = nm; v.n = n;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
    v.n_wr = nwr; v.n_smp = nsmp; v.n_err = nerr; v.last_addr = la;
    return v;
  endfunction

  vec_t vecs[9];

  initial begin
    int b_wr, b_smp, b_err;
    vecs[0] = mk("write",       2, 32'h0112_0000, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 8'h12);
    vecs[1] = mk("burst_wrap",  4, 32'h02FE_0003, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 0, 3, 0, 0, 8'h00);
    vecs[2] = mk("nop",         1, 32'h0055_0000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[3] = mk("burst_cnt0",  1, 32'h0210_0000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[4] = mk("stream_cnt0", 1, 32'h0320_0000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[5] = mk("bad_opcode",  2, 32'h7F00_0000, 32'h0000_0000, 0, 0, 0, 0, 0, 1, 8'h00);
    vecs[6] = mk("stream2",     3, 32'h0300_0002, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 2, 0, 8'h00);
    vecs[7] = mk("write_ff",    2, 32'h01FF_0000, 32'h0BAD_F00D, 0, 0, 0, 1, 0, 0, 8'hFF);
    vecs[8] = mk("burst2",      3, 32'h0230_0002, 32'h0000_0001, 32'h0000_0002, 0, 0, 2, 0, 0, 8'h31);

    // Power-on reset, then release and check the two-edge startup delay
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge synth_clk);
    #1 chk_reset_vals();
    fifo.push_back(32'h0000_0000);
    tick();
    tick();
    rst_n = 1'b1;
    drain(50);

    // Directed table
    foreach (vecs[i]) begin
      b_wr = obs_wr; b_smp = obs_smp; b_err = obs_err;
      for (int k = 0; k < vecs[i].n; k++) fifo.push_back(vecs[i].w[k]);
      drain(200);
      chk({vecs[i].name, "_nwr"},  obs_wr - b_wr,   vecs[i].n_wr);
      chk({vecs[i].name, "_nsmp"}, obs_smp - b_smp, vecs[i].n_smp);
      chk({vecs[i].name, "_nerr"}, obs_err - b_err, vecs[i].n_err);
      if (vecs[i].n_wr != 0) chk({vecs[i].name, "_addr"}, reg_addr, vecs[i].last_addr);
    end

    // Stream with 5 cycles of backpressure after the first sample
    b_smp = obs_smp;
    fifo.push_back(32'h0300_0004);
    for (int k = 0; k < 4; k++) fifo.push_back(32'h5000_0000 + k);
    for (int k = 0; k < 20 && !m_pend; k++) tick();
    rdy_low = 5;
    drain(200);
    chk("bp_nsmp", obs_smp - b_smp, 4);
    chk("bp_idle", idle, 1'b1);

    // Reset asserted mid-burst; leftover words become headers
    b_wr = obs_wr;
    fifo.push_back(32'h0240_0003);
    fifo.push_back(32'h1111_1111);
    fifo.push_back(32'h00AA_0000);
    fifo.push_back(32'h00BB_0000);
    for (int k = 0; k < 20 && !(m_mode == 2 && m_rem == 2); k++) tick();
    chk("mid_burst_pulse", reg_wr_en, 1'b1);
    rst_n = 1'b0;
    #1 chk_reset_vals();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    drain(100);
    chk("rst_burst_nwr", obs_wr - b_wr, 1);

    // Randomised frames with stalls and random backpressure
    rdy_rand = 1;
    for (int chunk = 0; chunk < 3; chunk++) begin
      stall_pct = 10 + 20 * chunk;
      for (int f = 0; f < 80; f++) begin
        int sel, cnt;
        logic [7:0] op;
        sel = $urandom_range(0, 9);
        cnt = $urandom_range(0, 5);
        case (sel)
          0, 1:    op = 8'h00;
          2, 3:    op = 8'h01;
          4, 5:    op = 8'h02;
          6, 7:    op = 8'h03;
          default: op = 8'($urandom_range(4, 255));
        endcase
        fifo.push_back({op, 8'($urandom_range(0, 255)), 16'(cnt)});
        if (op == 8'h01) fifo.push_back($urandom);
        else if (op == 8'h02 || op == 8'h03)
          for (int k = 0; k < cnt; k++) fifo.push_back($urandom);
      end
      drain(20000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
